// File: rtl/lr_stack_ctl_if.sv
// Call/return request, status and spill/fill memory signals of the link-register stack.
// slave is the stack controller side, master the pipeline/memory side.
interface lr_stack_ctl_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
);
   logic                     call_en;
   logic [DATA_W-1:0]        call_addr;
   logic                     ret_en;
   logic [DATA_W-1:0]        ret_addr;
   logic                     ret_valid;
   logic                     busy;
   logic                     mem_req;
   logic                     mem_we;
   logic [DATA_W-1:0]        mem_addr;
   logic [DATA_W-1:0]        mem_wdata;
   logic                     mem_ack;
   logic [DATA_W-1:0]        mem_rdata;
   logic [$clog2(DEPTH):0]   depth;
   logic                     ovf;
   logic                     unf;

   modport slave (
      input  call_en, call_addr, ret_en, mem_ack, mem_rdata,
      output ret_addr, ret_valid, busy, mem_req, mem_we, mem_addr, mem_wdata,
             depth, ovf, unf
   );

   modport master (
      output call_en, call_addr, ret_en, mem_ack, mem_rdata,
      input  ret_addr, ret_valid, busy, mem_req, mem_we, mem_addr, mem_wdata,
             depth, ovf, unf
   );
endinterface

// File: rtl/lr_stack_ctl.sv
// Return-address stack: DEPTH on-chip entries in a circular buffer, oldest entries
// spilled to / refilled from memory via a req/ack handshake while busy stalls the pipe.
module lr_stack_ctl #(
   parameter int                DATA_W      = 16,
   parameter int                DEPTH       = 4,
   parameter logic [DATA_W-1:0] SPILL_BASE  = 16'hFF00,
   parameter int                SPILL_DEPTH = 64
) (
   input logic           clk,
   input logic           reset_n,
   lr_stack_ctl_if.slave bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int DW  = PW + 1;
   localparam int SCW = $clog2(SPILL_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, SPILL, FILL} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   stk_q [DEPTH];
   logic [PW-1:0]       bot_q, bot_d;
   logic [DW-1:0]       cnt_q, cnt_d;
   logic [SCW-1:0]      spill_q, spill_d;
   logic [DATA_W-1:0]   pend_q, pend_d;
   logic                pend_push_q, pend_push_d;
   logic [DATA_W-1:0]   ret_addr_q, ret_addr_d;
   logic                ret_valid_q, ret_valid_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   logic                wr_en;
   logic [PW-1:0]       wr_idx;
   logic [DATA_W-1:0]   wr_data;
   logic [PW-1:0]       top_idx, free_idx;
   logic                idle, empty, full, spill_empty, spill_full;
   logic                pop_acc, push_acc, go_fill, go_spill;

   always_comb begin
      idle        = (state_q == IDLE);
      empty       = (cnt_q == '0);
      full        = (cnt_q == DW'(DEPTH));
      spill_empty = (spill_q == '0);
      spill_full  = (spill_q == SCW'(SPILL_DEPTH));
      top_idx     = bot_q + cnt_q[PW-1:0] - PW'(1);
      free_idx    = bot_q + cnt_q[PW-1:0];
      pop_acc     = idle & bus.ret_en;
      push_acc    = idle & bus.call_en;
      go_fill     = pop_acc & empty & ~spill_empty;
      go_spill    = push_acc & ~bus.ret_en & full & ~spill_full;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (go_fill) state_d = FILL;
                      else if (go_spill) state_d = SPILL;
         SPILL, FILL: if (bus.mem_ack) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Handshake outputs decode from state_q only, so reset drops mem_req asynchronously.
   always_comb begin
      bus.busy      = (state_q != IDLE);
      bus.mem_req   = (state_q != IDLE);
      bus.mem_we    = (state_q == SPILL);
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state_q)
         SPILL: begin
            bus.mem_addr  = SPILL_BASE + DATA_W'(spill_q);
            bus.mem_wdata = stk_q[bot_q];
         end
         FILL:    bus.mem_addr = SPILL_BASE + DATA_W'(spill_q) - DATA_W'(1);
         default: ;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      bot_d       = bot_q;
      spill_d     = spill_q;
      pend_d      = pend_q;
      pend_push_d = pend_push_q;
      ret_addr_d  = ret_addr_q;
      ret_valid_d = 1'b0;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      wr_en       = 1'b0;
      wr_idx      = free_idx;
      wr_data     = bus.call_addr;
      case (state_q)
         IDLE: begin
            if (pop_acc) begin
               if (!empty) begin
                  ret_addr_d  = stk_q[top_idx];
                  ret_valid_d = 1'b1;
                  // A simultaneous push simply replaces the popped top.
                  if (bus.call_en) begin
                     wr_en  = 1'b1;
                     wr_idx = top_idx;
                  end else begin
                     cnt_d = cnt_q - DW'(1);
                  end
               end else if (!spill_empty) begin
                  pend_d      = bus.call_addr;
                  pend_push_d = bus.call_en;
               end else begin
                  ret_addr_d  = '0;
                  ret_valid_d = 1'b1;
                  unf_d       = 1'b1;
                  if (bus.call_en) begin
                     wr_en = 1'b1;
                     cnt_d = DW'(1);
                  end
               end
            end else if (push_acc) begin
               if (!full) begin
                  wr_en = 1'b1;
                  cnt_d = cnt_q + DW'(1);
               end else if (!spill_full) begin
                  pend_d = bus.call_addr;
               end else begin
                  wr_en  = 1'b1;
                  wr_idx = bot_q;
                  bot_d  = bot_q + PW'(1);
                  ovf_d  = 1'b1;
               end
            end
         end
         SPILL: if (bus.mem_ack) begin
            // The freed bottom slot is exactly where the latched push lands.
            spill_d = spill_q + SCW'(1);
            wr_en   = 1'b1;
            wr_idx  = bot_q;
            wr_data = pend_q;
            bot_d   = bot_q + PW'(1);
         end
         FILL: if (bus.mem_ack) begin
            ret_addr_d  = bus.mem_rdata;
            ret_valid_d = 1'b1;
            spill_d     = spill_q - SCW'(1);
            if (pend_push_q) begin
               wr_en   = 1'b1;
               wr_data = pend_q;
               cnt_d   = DW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         bot_q       <= '0;
         spill_q     <= '0;
         pend_q      <= '0;
         pend_push_q <= 1'b0;
         ret_addr_q  <= '0;
         ret_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bot_q       <= bot_d;
         spill_q     <= spill_d;
         pend_q      <= pend_d;
         pend_push_q <= pend_push_d;
         ret_addr_q  <= ret_addr_d;
         ret_valid_q <= ret_valid_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) stk_q[wr_idx] <= wr_data;
   end

   assign bus.ret_addr  = ret_addr_q;
   assign bus.ret_valid = ret_valid_q;
   assign bus.depth     = cnt_q;
   assign bus.ovf       = ovf_q;
   assign bus.unf       = unf_q;
endmodule

// File: tb/tb_lr_stack_ctl.sv
// Directed bench for lr_stack_ctl: a cycle table for the main call/return/spill/fill flow,
// plus hand sequences for reset during a spill, spill-area overflow and fill with a pending push.
module tb_lr_stack_ctl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   lr_stack_ctl_if #(.DATA_W(16), .DEPTH(4)) bus ();

   lr_stack_ctl #(
      .DATA_W(16), .DEPTH(4), .SPILL_BASE(16'hFF00), .SPILL_DEPTH(64)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   typedef struct {
      logic c; logic [15:0] ca; logic r; logic ack; logic [15:0] rd;
      logic rv; logic [15:0] ra; logic bsy; logic req; logic we;
      logic [15:0] ma; logic [15:0] wd; logic [2:0] dep; logic ovf; logic unf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic c, logic [15:0] ca, logic r, logic ack, logic [15:0] rd,
                               logic rv, logic [15:0] ra, logic bsy, logic req, logic we,
                               logic [15:0] ma, logic [15:0] wd, logic [2:0] dep,
                               logic ovf, logic unf);
      vec_t v;
      v.c = c; v.ca = ca; v.r = r; v.ack = ack; v.rd = rd;
      v.rv = rv; v.ra = ra; v.bsy = bsy; v.req = req; v.we = we;
      v.ma = ma; v.wd = wd; v.dep = dep; v.ovf = ovf; v.unf = unf;
      return v;
   endfunction

   function automatic logic [56:0] outs();
      return {bus.ret_valid, bus.ret_addr, bus.busy, bus.mem_req, bus.mem_we,
              bus.mem_addr, bus.mem_wdata, bus.depth, bus.ovf, bus.unf};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic [15:0] ca, input logic r,
                        input logic ack, input logic [15:0] rd);
      bus.call_en = c; bus.call_addr = ca; bus.ret_en = r;
      bus.mem_ack = ack; bus.mem_rdata = rd;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(0, '0, 0, 0, '0);
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic wait_req(input string nm);
      for (int i = 0; i < 16; i++) begin
         if (bus.mem_req) return;
         tick();
      end
      chk({nm, "_req_timeout"}, 64'(bus.mem_req), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // c ca r ack rd | rv ra bsy req we ma wd dep ovf unf
      tbl.push_back(mk(1,16'h0010,0,0,0, 0,16'h0000,0,0,0,0,0,1,0,0));
      tbl.push_back(mk(1,16'h0020,0,0,0, 0,16'h0000,0,0,0,0,0,2,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0020,0,0,0,0,0,1,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0010,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,16'h0010,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(1,16'h0001,0,0,0, 0,16'h0010,0,0,0,0,0,1,0,0));
      tbl.push_back(mk(1,16'h0002,0,0,0, 0,16'h0010,0,0,0,0,0,2,0,0));
      tbl.push_back(mk(1,16'h0003,0,0,0, 0,16'h0010,0,0,0,0,0,3,0,0));
      tbl.push_back(mk(1,16'h0004,0,0,0, 0,16'h0010,0,0,0,0,0,4,0,0));
      tbl.push_back(mk(1,16'h0005,0,0,0, 0,16'h0010,1,1,1,16'hFF00,16'h0001,4,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,16'h0010,1,1,1,16'hFF00,16'h0001,4,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,16'h0010,1,1,1,16'hFF00,16'h0001,4,0,0));
      tbl.push_back(mk(0,0,0,1,0,        0,16'h0010,0,0,0,0,0,4,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0005,0,0,0,0,0,3,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0004,0,0,0,0,0,2,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0003,0,0,0,0,0,1,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0002,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,        0,16'h0002,1,1,0,16'hFF00,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,16'h0002,1,1,0,16'hFF00,0,0,0,0));
      tbl.push_back(mk(0,0,0,1,16'h0001, 1,16'h0001,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,        0,16'h0001,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0000,0,0,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,        0,16'h0000,0,0,0,0,0,0,0,1));
      tbl.push_back(mk(1,16'h0030,0,0,0, 0,16'h0000,0,0,0,0,0,1,0,1));
      tbl.push_back(mk(1,16'h0040,1,0,0, 1,16'h0030,0,0,0,0,0,1,0,1));
      tbl.push_back(mk(0,0,1,0,0,        1,16'h0040,0,0,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,1,16'hBEEF, 0,16'h0040,0,0,0,0,0,0,0,1));

      drive(0, '0, 0, 0, '0);
      tick();
      chk("reset_outputs", 64'(outs()), 64'd0);
      do_reset();

      for (int i = 0; i < tbl.size(); i++) begin
         vec_t v;
         v = tbl[i];
         drive(v.c, v.ca, v.r, v.ack, v.rd);
         tick();
         chk($sformatf("vec%0d", i), 64'(outs()),
             64'({v.rv, v.ra, v.bsy, v.req, v.we, v.ma, v.wd, v.dep, v.ovf, v.unf}));
      end

      // Reset asserted while a spill request is outstanding.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1, 16'h0060 + 16'(i), 0, 0, '0);
         tick();
      end
      drive(0, '0, 0, 0, '0);
      chk("rst_spill_req", 64'({bus.mem_req, bus.mem_we, bus.mem_addr}), 64'({2'b11, 16'hFF00}));
      #3 reset_n = 1'b0;
      #1;
      chk("rst_async_drop", 64'({bus.mem_req, bus.busy, bus.depth}), 64'd0);
      tick();
      tick();
      reset_n = 1'b1;
      drive(1, 16'h0050, 0, 0, '0);
      tick();
      drive(0, '0, 1, 0, '0);
      tick();
      drive(0, '0, 0, 0, '0);
      chk("rst_repush_pop", 64'({bus.ret_valid, bus.ret_addr, bus.depth}), 64'({1'b1, 16'h0050, 3'd0}));

      // Fill the spill area, then overflow in place.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'h0100 + 16'(i), 0, 0, '0);
         tick();
      end
      for (int s = 0; s < 64; s++) begin
         logic [15:0] exp_wd;
         exp_wd = (s < 4) ? 16'h0100 + 16'(s) : 16'h0200 + 16'(s - 4);
         drive(1, 16'h0200 + 16'(s), 0, 0, '0);
         tick();
         drive(0, '0, 0, 0, '0);
         wait_req($sformatf("spill%0d", s));
         chk($sformatf("spill%0d_bus", s), 64'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
             64'({1'b1, 16'hFF00 + 16'(s), exp_wd}));
         drive(0, '0, 0, 1, '0);
         tick();
         drive(0, '0, 0, 0, '0);
         chk($sformatf("spill%0d_done", s), 64'({bus.busy, bus.mem_req, bus.depth}), 64'({2'b00, 3'd4}));
      end
      drive(1, 16'h0777, 0, 0, '0);
      tick();
      drive(0, '0, 0, 0, '0);
      chk("ovf_push", 64'({bus.busy, bus.mem_req, bus.ovf, bus.unf, bus.depth}), 64'({4'b0010, 3'd4}));
      begin
         logic [15:0] exp_pop [4];
         exp_pop = '{16'h0777, 16'h023F, 16'h023E, 16'h023D};
         for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, 0, '0);
            tick();
            chk($sformatf("ovf_pop%0d", i), 64'({bus.ret_valid, bus.ret_addr, bus.depth}),
                64'({1'b1, exp_pop[i], 3'(3 - i)}));
         end
      end

      // Call and return together on an empty on-chip stack: fill first, push on exit.
      drive(1, 16'h0888, 1, 0, '0);
      tick();
      drive(0, '0, 0, 0, '0);
      wait_req("fillpush");
      chk("fillpush_bus", 64'({bus.mem_we, bus.mem_addr, bus.busy}), 64'({1'b0, 16'hFF3F, 1'b1}));
      drive(0, '0, 0, 1, 16'h023B);
      tick();
      drive(0, '0, 0, 0, '0);
      chk("fillpush_ret", 64'({bus.ret_valid, bus.ret_addr, bus.depth, bus.busy}),
          64'({1'b1, 16'h023B, 3'd1, 1'b0}));
      drive(0, '0, 1, 0, '0);
      tick();
      drive(0, '0, 0, 0, '0);
      chk("fillpush_top", 64'({bus.ret_valid, bus.ret_addr, bus.depth, bus.ovf, bus.unf}),
          64'({1'b1, 16'h0888, 3'd0, 2'b10}));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
